// File: rtl/bus_fifo_pkg.sv
// Shared definitions for the bus-side packet FIFOs (source FIFO now, sink monitor FIFO later).
// Packets carry their destination device ID in the top ID_W bits.
package bus_fifo_pkg;

  localparam int ID_W          = 8;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);

  // Pointer and occupancy types for the default depth; count needs one extra bit to hold "full".
  typedef logic [DEFAULT_PTR_W-1:0] ptr_t;
  typedef logic [DEFAULT_PTR_W:0]   cnt_t;

  // Pointer width for an arbitrary depth, never narrower than one bit.
  function automatic int ptr_w(input int d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

  // Destination ID of a packet of pkt_w bits, passed in zero-extended to 64 bits.
  function automatic logic [ID_W-1:0] dest_of(input logic [63:0] pkt, input int pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_fifo_ram.sv
// Packet storage for the bus FIFOs: depth x width registers, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module bus_fifo_ram #(
  parameter int width = 16,
  parameter int depth = 8,
  parameter int aw    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  // Store the incoming packet in the addressed slot on an accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_src_fifo.sv
// Per-device source FIFO feeding the bus generator/arbiter. The device pushes packets; the bus
// sees a first-word-fall-through head (pndng / D_pop) and consumes it with pop. Self-addressed
// packets and writes into a full FIFO (without a same-cycle pop) are rejected with a wr_err pulse.
// Optional: define BUS_SRC_FIFO_DROP_CNT_EN to add a saturating 16-bit rejected-write counter.
module bus_src_fifo
  import bus_fifo_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int id      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [pckg_sz-1:0]     wr_data,
  output logic                   full,
  output logic                   wr_err,
  output logic                   pndng,
  input  logic                   pop,
  output logic [pckg_sz-1:0]     D_pop,
  output logic [$clog2(depth):0] count
`ifdef BUS_SRC_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int PTR_W = ptr_w(depth);
  localparam int CNT_W = $clog2(depth) + 1;

  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic               full_q, pndng_q, wr_err_q;
  logic               pop_eff, dest_ok, room, wr_acc, wr_rej;
  logic [pckg_sz-1:0] rd_data;

  // Decide this cycle's pop and write acceptance; a pop frees a slot for a same-cycle write.
  always_comb begin
    pop_eff = pop & pndng_q;
    dest_ok = dest_of(64'(wr_data), pckg_sz) != ID_W'(id);
    room    = ~full_q | pop_eff;
    wr_acc  = wr_en & room & dest_ok;
    wr_rej  = wr_en & ~(room & dest_ok);
  end

  // Next occupancy: push+pop cancels out, otherwise step up or down.
  always_comb begin
    count_nxt = count_q;
    case ({wr_acc, pop_eff})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointer, occupancy and status registers; reset discards everything and ignores wr_en/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      pndng_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      if (wr_acc)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q  <= count_nxt;
      full_q   <= (count_nxt == CNT_W'(depth));
      pndng_q  <= (count_nxt != '0);
      wr_err_q <= wr_rej;
    end
  end

  bus_fifo_ram #(
    .width (pckg_sz),
    .depth (depth),
    .aw    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~reset),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef BUS_SRC_FIFO_DROP_CNT_EN
  // Count rejected writes in the rejection cycle, saturating instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)                          drop_cnt <= '0;
    else if (wr_rej && drop_cnt != '1)  drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  assign full   = full_q;
  assign pndng  = pndng_q;
  assign wr_err = wr_err_q;
  assign count  = count_q;
  // Head is masked to zero while empty so stale memory never shows after reset or drain.
  assign D_pop  = pndng_q ? rd_data : '0;

endmodule

// File: tb/tb_bus_src_fifo.sv
// Self-checking bench for bus_src_fifo: a table of directed vectors on an id=0 instance,
// plus hand-written sequences for self-addressed rejection (id=3 instance), pointer wrap
// with a queue model, and reset in the middle of traffic.
module tb_bus_src_fifo;

  logic        clk = 1'b0;
  logic        reset, wr_en, pop;
  logic [15:0] wr_data;
  logic        full, wr_err, pndng;
  logic [15:0] d_pop;
  logic [3:0]  count;

  logic        w3_en, p3;
  logic [15:0] w3_data;
  logic        full3, err3, pndng3;
  logic [15:0] d_pop3;
  logic [3:0]  count3;

`ifdef BUS_SRC_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt, drop_cnt3;
`endif

  always #5 clk = ~clk;

  bus_src_fifo #(.pckg_sz(16), .depth(8), .id(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .wr_err(wr_err), .pndng(pndng), .pop(pop), .D_pop(d_pop), .count(count)
`ifdef BUS_SRC_FIFO_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  bus_src_fifo #(.pckg_sz(16), .depth(8), .id(3)) dut3 (
    .clk(clk), .reset(reset), .wr_en(w3_en), .wr_data(w3_data), .full(full3),
    .wr_err(err3), .pndng(pndng3), .pop(p3), .D_pop(d_pop3), .count(count3)
`ifdef BUS_SRC_FIFO_DROP_CNT_EN
    , .drop_cnt(drop_cnt3)
`endif
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        pop;
    logic        e_pndng;
    logic        e_full;
    logic        e_err;
    logic [3:0]  e_count;
    logic [15:0] e_dpop;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string n, input logic r, input logic w, input logic [15:0] d,
                              input logic p, input logic ep, input logic ef, input logic ee,
                              input logic [3:0] ec, input logic [15:0] ed);
    vec_t v;
    v.name = n; v.rst = r; v.wr_en = w; v.wr_data = d; v.pop = p;
    v.e_pndng = ep; v.e_full = ef; v.e_err = ee; v.e_count = ec; v.e_dpop = ed;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then sample 1 time unit later.
  task automatic applyStimulus(input vec_t v);
    reset   = v.rst;
    wr_en   = v.wr_en;
    wr_data = v.wr_data;
    pop     = v.pop;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput({v.name, ".pndng"},  16'(pndng),  16'(v.e_pndng));
    checkOutput({v.name, ".full"},   16'(full),   16'(v.e_full));
    checkOutput({v.name, ".wr_err"}, 16'(wr_err), 16'(v.e_err));
    checkOutput({v.name, ".count"},  16'(count),  16'(v.e_count));
    checkOutput({v.name, ".D_pop"},  d_pop,       v.e_dpop);
  endtask

  logic [15:0] q[$];
  logic        dw, dp, pe, acc;
  logic [15:0] head;

  initial begin
    reset = 1'b1; wr_en = 1'b0; pop = 1'b0; wr_data = '0;
    w3_en = 1'b0; p3 = 1'b0; w3_data = '0;

    // Reset, idle pop, fill, overflow, push+pop at full, drain.
    vecs.push_back(mk("rst0", 1, 0, 16'h0, 0, 0, 0, 0, 4'd0, 16'h0));
    vecs.push_back(mk("rst1", 1, 0, 16'h0, 0, 0, 0, 0, 4'd0, 16'h0));
    vecs.push_back(mk("pop_empty", 0, 0, 16'h0, 1, 0, 0, 0, 4'd0, 16'h0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk($sformatf("fill%0d", k), 0, 1, {8'(k), 8'h01}, 0,
                        1, (k == 8), 0, 4'(k), 16'h0101));
    vecs.push_back(mk("overflow", 0, 1, 16'h0AAA, 0, 1, 1, 1, 4'd8, 16'h0101));
    vecs.push_back(mk("ovf_after", 0, 0, 16'h0, 0, 1, 1, 0, 4'd8, 16'h0101));
    vecs.push_back(mk("pushpop_full", 0, 1, 16'h0BBB, 1, 1, 1, 0, 4'd8, 16'h0201));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk($sformatf("drain%0d", k), 0, 0, 16'h0, 1, 1, 0, 0, 4'(8 - k),
                        (k <= 6) ? {8'(k + 2), 8'h01} : 16'h0BBB));
    vecs.push_back(mk("drain_last", 0, 0, 16'h0, 1, 0, 0, 0, 4'd0, 16'h0));
    vecs.push_back(mk("pop_empty2", 0, 0, 16'h0, 1, 0, 0, 0, 4'd0, 16'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i]);
    end

`ifdef BUS_SRC_FIFO_DROP_CNT_EN
    checkOutput("drop_cnt_overflow", drop_cnt, 16'd1);
`endif

    // Self-addressed packet on the id=3 port is rejected; dest 4 is accepted.
    w3_en = 1'b1; w3_data = 16'h03FF;
    @(posedge clk); #1;
    checkOutput("self.wr_err", 16'(err3), 16'd1);
    checkOutput("self.count", 16'(count3), 16'd0);
    checkOutput("self.pndng", 16'(pndng3), 16'd0);
    w3_data = 16'h04FF;
    @(posedge clk); #1;
    checkOutput("other.wr_err", 16'(err3), 16'd0);
    checkOutput("other.count", 16'(count3), 16'd1);
    checkOutput("other.D_pop", d_pop3, 16'h04FF);
    w3_en = 1'b0;
`ifdef BUS_SRC_FIFO_DROP_CNT_EN
    checkOutput("drop_cnt_self", drop_cnt3, 16'd1);
`endif

    // Interleaved push/pop across the pointer wrap, checked against a queue model.
    q.delete();
    for (int i = 0; i < 20; i++) begin
      dw  = (i % 4) != 3;
      dp  = (i % 2) == 1;
      pe  = dp && (q.size() != 0);
      acc = dw && ((q.size() < 8) || pe);
      if (pe)  void'(q.pop_front());
      if (acc) q.push_back(16'(16'h1000 + i));
      applyStimulus(mk("wrap", 0, dw, 16'(16'h1000 + i), dp, 0, 0, 0, 4'd0, 16'h0));
      head = (q.size() != 0) ? q[0] : 16'h0;
      checkOutput($sformatf("wrap%0d.count", i), 16'(count), 16'(q.size()));
      checkOutput($sformatf("wrap%0d.D_pop", i), d_pop, head);
      checkOutput($sformatf("wrap%0d.wr_err", i), 16'(wr_err), 16'(dw && !acc));
    end

    // Reset in the middle of traffic with 5 stored packets; wr_en/pop that cycle are ignored.
    vecs.delete();
    vecs.push_back(mk("mid_rst0", 1, 0, 16'h0, 0, 0, 0, 0, 4'd0, 16'h0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk($sformatf("mid_fill%0d", k), 0, 1, 16'(16'h2000 + k), 0,
                        1, 0, 0, 4'(k), 16'h2001));
    vecs.push_back(mk("mid_rst", 1, 1, 16'h0777, 1, 0, 0, 0, 4'd0, 16'h0));
    vecs.push_back(mk("post_rst_wr", 0, 1, 16'h0123, 0, 1, 0, 0, 4'd1, 16'h0123));
    vecs.push_back(mk("post_rst_pop", 0, 0, 16'h0, 1, 0, 0, 0, 4'd0, 16'h0));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_src_fifo.md
Name: bus_src_fifo

Overview:
- Per-device source FIFO sitting directly upstream of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- The device side writes packets in. The bus side sees a first-word-fall-through head (pndng, D_pop) and pops it with pop.
- One instance per bus driver (drvrs instances). Replaces the behavioural driver-side FIFO used in simulation with synthesizable RTL.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 : pckg_sz-8] hold the destination ID.
- depth, 8, number of packet slots; power of two, minimum 2.
- id, 0, this port's device ID; used only for self-addressed packet rejection.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  device write request.
- wr_data  in  pckg_sz  packet to enqueue.
- full  out  1  no free slot (count == depth).
- wr_err  out  1  one-cycle pulse: write rejected (overflow or self-addressed).
- pndng  out  1  head packet valid (count != 0).
- pop  in  1  bus consumes head this cycle.
- D_pop  out  pckg_sz  head packet; valid while pndng = 1.
- count  out  $clog2(depth)+1  current occupancy.

Behaviour:
- Reset: synchronous, active-high, sampled on clk rise. It clears rd_ptr, wr_ptr and count. Outputs become pndng=0, full=0, wr_err=0, count=0, D_pop=0. Memory contents are not cleared. Reset during traffic discards all stored packets, and any wr_en/pop in that same cycle is ignored.
- Storage: circular buffer, log2(depth)-bit pointers that wrap naturally from depth-1 to 0. count is tracked separately so full and empty are unambiguous.
- Write acceptance: wr_en accepted when (count < depth or pop_eff) and dest(wr_data) != id.
  - Accepted: mem[wr_ptr] <= wr_data; wr_ptr++.
- Rejected write: wr_err = 1 for exactly the next cycle. Causes:
  - full without pop;
  - dest == id (a self-addressed packet is illegal on the bus).
  - The FIFO state is unchanged by a rejected write.
- Pop: pop_eff = pop & pndng; rd_ptr++.
  - pop while pndng = 0 is ignored silently.
- Simultaneous push and pop:
  - Count unchanged.
  - When full, the write is accepted because the pop frees the slot in the same cycle.
  - When empty, only the write takes effect.
- Latency:
  - A write accepted at edge N gives pndng = 1 and D_pop = that packet after edge N, so the bus can pop it in cycle N+1.
  - After a pop at edge N, D_pop shows the next entry after edge N.
- Registered outputs: pndng, full and count are registered (next-state logic). D_pop is mem[rd_ptr] combinational from registered state, glitch-free per cycle.
- Ordering: strict FIFO; packets are never reordered or duplicated.

Optional Feature:
- Macro: BUS_SRC_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [15:0], reset to 0.
  - Increments by 1 on every cycle with wr_err asserted-cause (i.e. the rejection cycle), saturating at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package bus_fifo_pkg:
  - localparam ID_W = 8;
  - function dest_of(pkt) returning the top ID_W bits;
  - typedef for the pointer/count widths derived via $clog2.
  - Shared with the sink-side monitor FIFO later.
- Sub-module bus_fifo_ram: depth x pckg_sz register array, one write port, one asynchronous read port. The control logic stays in bus_src_fifo.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> pndng=0, full=0, count=0, wr_err=0. A pop=1 while empty leaves count=0 and gives no wr_err.
- Fill/drain, depth=8, id=0: write 16'h0101..16'h0801 on consecutive cycles.
  - full=1 after the 8th write; count=8.
  - Pop 8 times -> D_pop sequence 0101..0801 in order, then pndng=0.
- Overflow: at full, wr_en with 16'h0AAA and pop=0 -> wr_err pulses 1 cycle, count stays 8, D_pop head unchanged.
  - With the macro defined, drop_cnt = 1.
- Full with simultaneous push+pop: at full, wr_en=16'h0BBB and pop=1 -> count stays 8 and no wr_err. 16'h0BBB is popped last after 7 further pops.
- Self-addressed reject, id=3: wr_data=16'h03FF -> wr_err pulse, count unchanged. wr_data=16'h04FF is accepted.
- Wrap and reset mid-traffic:
  - 20 interleaved push/pop cycles crossing the pointer wrap -> data order is preserved.
  - Asserting reset with count=5 -> next cycle count=0, pndng=0. A subsequent write of 16'h0123 appears on D_pop one cycle later.
